// File: rtl/up_counter_timer.sv
// ============================================================================
// Module  : up_counter_timer
// Brief   : Up-counting programmable timer, one-shot or periodic, with a
//           terminal-count pulse. Optional prescaler via UP_CNT_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module up_counter_timer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
`ifdef UP_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   limit_q;
    logic               mode_q;
    logic               tc_q;
    logic               busy_q;
    logic               done_q;
    logic               tick;

`ifdef UP_CNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_cnt_q;

    assign tick = (pre_cnt_q == prescale_q);

    // Prescaler only advances in RUN; every other situation restarts it at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else if (stop) begin
            pre_cnt_q  <= '0;
        end else if (start) begin
            prescale_q <= prescale;
            pre_cnt_q  <= '0;
        end else if (state_q == S_RUN) begin
            pre_cnt_q  <= tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
        end else begin
            pre_cnt_q  <= '0;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (stop) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= S_RUN;
            count_q <= '0;
            limit_q <= limit;
            mode_q  <= mode;
            tc_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!tick) begin
                        tc_q <= 1'b0;
                    end else if (count_q == limit_q) begin
                        // Count never passes limit_q, so the increment cannot overflow.
                        tc_q <= 1'b1;
                        if (mode_q) begin
                            count_q <= '0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                        tc_q    <= 1'b0;
                    end
                end
                default: begin
                    tc_q <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_up_counter_timer.sv
// ============================================================================
// Module  : tb_up_counter_timer
// Brief   : Randomised and directed checking of up_counter_timer against an
//           arithmetic reference model (elapsed cycles since start).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_counter_timer;

    localparam int WIDTH = 4;
    localparam int PW    = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [PW-1:0]    prescale;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    up_counter_timer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
`ifdef UP_CNT_PRESCALE_EN
        .prescale (prescale),
`endif
        .limit    (limit),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a timer is either inactive or has been running for
    // m_n clock edges since its start edge.
    bit m_act;
    int m_n;
    int m_l;
    bit m_m;
    int m_p;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_n = 0; m_l = 0; m_m = 0; m_p = 0;
    endtask

    task automatic model_edge();
        if (stop) begin
            m_act = 0;
        end else if (start) begin
            m_act = 1;
            m_n   = 0;
            m_l   = int'(limit);
            m_m   = mode;
`ifdef UP_CNT_PRESCALE_EN
            m_p   = int'(prescale);
`else
            m_p   = 0;
`endif
        end else if (m_act) begin
            m_n++;
        end
    endtask

    task automatic compare_all(input string tag);
        int e_cnt, e_tc, e_busy, e_done, ticks;
        bit on_tick;
        e_cnt = 0; e_tc = 0; e_busy = 0; e_done = 0;
        if (m_act) begin
            ticks   = m_n / (m_p + 1);
            on_tick = (m_n > 0) && (m_n % (m_p + 1) == 0);
            if (m_m) begin
                e_cnt  = ticks % (m_l + 1);
                e_tc   = (on_tick && ticks > 0 && (ticks % (m_l + 1) == 0)) ? 1 : 0;
                e_busy = 1;
            end else if (ticks <= m_l) begin
                e_cnt  = ticks;
                e_busy = 1;
            end else begin
                e_cnt  = m_l;
                e_done = 1;
                e_tc   = (on_tick && ticks == m_l + 1) ? 1 : 0;
            end
        end
        check_val({tag, ".count"}, int'(count), e_cnt);
        check_val({tag, ".tc"},    int'(tc),    e_tc);
        check_val({tag, ".busy"},  int'(busy),  e_busy);
        check_val({tag, ".done"},  int'(done),  e_done);
    endtask

    // Called at a negedge: apply inputs, clock once, check at the next negedge.
    task automatic cyc(input string tag, input logic st, input logic sp,
                       input logic md, input int lm, input int ps);
        start    = st;
        stop     = sp;
        mode     = md;
        limit    = WIDTH'(lm);
        prescale = PW'(ps);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n, input int lm);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, lm, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        limit = '0; prescale = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // Periodic, limit 3
        cyc("per3_start", 1'b1, 1'b0, 1'b1, 3, 0);
        idle_cycles("per3", 12, 3);

        // One-shot, limit 5, then hold in DONE, then restart
        cyc("os5_start", 1'b1, 1'b0, 1'b0, 5, 0);
        idle_cycles("os5", 28, 5);
        cyc("os5_restart", 1'b1, 1'b0, 1'b0, 5, 0);
        idle_cycles("os5_re", 3, 5);

        // Limit 0 one-shot and periodic
        cyc("os0_start", 1'b1, 1'b0, 1'b0, 0, 0);
        idle_cycles("os0", 3, 0);
        cyc("per0_start", 1'b1, 1'b0, 1'b1, 0, 0);
        idle_cycles("per0", 6, 0);

        // Max limit, periodic
        cyc("per15_start", 1'b1, 1'b0, 1'b1, 15, 0);
        idle_cycles("per15", 20, 15);

        // stop + start together with count = 2
        cyc("col_a", 1'b1, 1'b0, 1'b1, 6, 0);
        idle_cycles("col_a", 2, 6);
        check_val("col_a.pre_cnt", int'(count), 2);
        cyc("col_stopstart", 1'b1, 1'b1, 1'b1, 6, 0);
        idle_cycles("col_idle", 2, 6);

        // start alone with count = 2 relatches limit
        cyc("col_b", 1'b1, 1'b0, 1'b1, 6, 0);
        idle_cycles("col_b", 2, 6);
        cyc("col_restart", 1'b1, 1'b0, 1'b1, 2, 0);
        idle_cycles("col_relatch", 6, 2);

        // Limit change mid-run has no effect
        cyc("lchg_start", 1'b1, 1'b0, 1'b1, 3, 0);
        idle_cycles("lchg", 10, 9);

        // start held high keeps count at 0
        for (int i = 0; i < 3; i++) cyc("hold_start", 1'b1, 1'b0, 1'b1, 4, 0);
        cyc("stop_run", 1'b0, 1'b1, 1'b0, 4, 0);
        cyc("stop_idle", 1'b0, 1'b1, 1'b0, 4, 0);

`ifdef UP_CNT_PRESCALE_EN
        cyc("pre2_start", 1'b1, 1'b0, 1'b1, 1, 2);
        for (int i = 0; i < 14; i++) cyc("pre2", 1'b0, 1'b0, 1'b1, 1, 2);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                1'($urandom), int'($urandom_range(0, 15)),
`ifdef UP_CNT_PRESCALE_EN
                int'($urandom_range(0, 3))
`else
                0
`endif
            );
        end

        // Asynchronous reset with count = 7
        cyc("ar_start", 1'b1, 1'b0, 1'b1, 10, 0);
        idle_cycles("ar", 7, 10);
        check_val("ar.pre_cnt", int'(count), 7);
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle_cycles("after_rst", 4, 10);
        cyc("resume", 1'b1, 1'b0, 1'b1, 2, 0);
        idle_cycles("resume", 5, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
